// File: rtl/vector_reg_file_masked.sv
// rtl/vector_reg_file_masked.sv - masked-lane vector register file with clear sweep and pending flags
module vector_reg_file_masked #(
  parameter int regSize     = 8,
  parameter int regQuantity = 8,
  parameter int selBits     = 3,
  parameter int vecSize     = 4
) (
  input  logic                             clk,
  input  logic                             reset,
  input  logic                             regWrEn,
  input  logic [selBits-1:0]               regToWrite,
  input  logic [vecSize-1:0][regSize-1:0]  regWriteData,
  input  logic [vecSize-1:0]               wrMask,
  input  logic [selBits-1:0]               rSel1,
  input  logic [selBits-1:0]               rSel2,
  output logic [vecSize-1:0][regSize-1:0]  reg1Out,
  output logic [vecSize-1:0][regSize-1:0]  reg2Out,
  input  logic                             clrReq,
  output logic                             clrBusy,
  output logic                             clrDone,
  output logic                             wrDropped,
  input  logic                             pendSet,
  input  logic [selBits-1:0]               pendSel,
  output logic [regQuantity-1:0]           pendVec,
  output logic                             pend1,
  output logic                             pend2
);

  typedef enum logic [1:0] {IDLE, SWEEP, DONE} clrState_t;

  localparam logic [selBits-1:0] lastIdx = selBits'(regQuantity - 1);

  clrState_t                       state;
  clrState_t                       nextState;
  logic [selBits-1:0]              sweepCnt;
  logic [vecSize-1:0][regSize-1:0] regFile [regQuantity];
  logic                            wrAccept;

  assign wrAccept  = regWrEn && (state == IDLE);
  assign wrDropped = regWrEn && clrBusy;
  assign pend1     = pendVec[rSel1];
  assign pend2     = pendVec[rSel2];

  always_comb begin
    nextState = state;
    clrBusy   = 1'b0;
    clrDone   = 1'b0;
    case (state)
      IDLE:  if (clrReq) nextState = SWEEP;
      SWEEP: begin
        clrBusy = 1'b1;
        if (sweepCnt == lastIdx) nextState = DONE;
      end
      DONE: begin
        clrBusy   = 1'b1;
        clrDone   = 1'b1;
        nextState = IDLE;
      end
      default: nextState = IDLE;
    endcase
  end

  // Counter sits at zero outside SWEEP, so entering SWEEP always starts at register 0.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state    <= IDLE;
      sweepCnt <= '0;
    end else begin
      state <= nextState;
      if (state == SWEEP) sweepCnt <= sweepCnt + 1'b1;
      else                sweepCnt <= '0;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int r = 0; r < regQuantity; r++) regFile[r] <= '0;
    end else if (state == SWEEP) begin
      regFile[sweepCnt] <= '0;
    end else if (wrAccept) begin
      for (int i = 0; i < vecSize; i++)
        if (wrMask[i]) regFile[regToWrite][i] <= regWriteData[i];
    end
  end

  // Set is applied after the write-clear so a same-register set wins.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pendVec <= '0;
    end else if (state == IDLE) begin
      if (clrReq) begin
        pendVec <= '0;
      end else begin
        if (regWrEn) pendVec[regToWrite] <= 1'b0;
        if (pendSet) pendVec[pendSel]    <= 1'b1;
      end
    end
  end

  always_comb begin
    reg1Out = regFile[rSel1];
    reg2Out = regFile[rSel2];
    for (int i = 0; i < vecSize; i++) begin
      if (wrAccept && wrMask[i] && (rSel1 == regToWrite)) reg1Out[i] = regWriteData[i];
      if (wrAccept && wrMask[i] && (rSel2 == regToWrite)) reg2Out[i] = regWriteData[i];
    end
  end

endmodule

// File: tb/tb_vector_reg_file_masked.sv
// tb/tb_vector_reg_file_masked.sv - scoreboard bench for vector_reg_file_masked
module tb_vector_reg_file_masked;

  logic        clk = 1'b0;
  logic        reset;
  logic        regWrEn;
  logic [2:0]  regToWrite;
  logic [31:0] regWriteData;
  logic [3:0]  wrMask;
  logic [2:0]  rSel1, rSel2;
  logic [31:0] reg1Out, reg2Out;
  logic        clrReq, clrBusy, clrDone, wrDropped;
  logic        pendSet;
  logic [2:0]  pendSel;
  logic [7:0]  pendVec;
  logic        pend1, pend2;

  int          checks = 0;
  int          errors = 0;
  logic [31:0] expQ[$];
  logic [31:0] exp;

  vector_reg_file_masked dut (
    .clk(clk), .reset(reset), .regWrEn(regWrEn), .regToWrite(regToWrite),
    .regWriteData(regWriteData), .wrMask(wrMask), .rSel1(rSel1), .rSel2(rSel2),
    .reg1Out(reg1Out), .reg2Out(reg2Out), .clrReq(clrReq), .clrBusy(clrBusy),
    .clrDone(clrDone), .wrDropped(wrDropped), .pendSet(pendSet), .pendSel(pendSel),
    .pendVec(pendVec), .pend1(pend1), .pend2(pend2)
  );

  always #5 clk = ~clk;

  task automatic idleInputs();
    regWrEn = 0; regToWrite = 0; regWriteData = 0; wrMask = 0;
    clrReq = 0; pendSet = 0; pendSel = 0;
  endtask

  task automatic doWrite(input logic [2:0] sel, input logic [31:0] data, input logic [3:0] mask);
    @(negedge clk);
    regWrEn = 1; regToWrite = sel; regWriteData = data; wrMask = mask;
    @(negedge clk);
    regWrEn = 0;
  endtask

  task automatic test_reset();
    reset = 0; idleInputs(); rSel1 = 1; rSel2 = 0;
    #2;
    checks++;
    if ({reg1Out, reg2Out} !== 64'h0) begin errors++; $display("FAIL reset_regs: got %h/%h expected 0/0", reg1Out, reg2Out); end
    checks++;
    if ({clrBusy, clrDone, wrDropped, pendVec} !== 11'h0) begin
      errors++; $display("FAIL reset_flags: busy=%b done=%b drop=%b pend=%h expected all 0", clrBusy, clrDone, wrDropped, pendVec);
    end
    @(negedge clk); reset = 1;
  endtask

  task automatic test_write_full();
    @(negedge clk);
    regWrEn = 1; regToWrite = 1; regWriteData = 32'hDEADBEEF; wrMask = 4'hF; rSel1 = 1; rSel2 = 0;
    expQ.push_back(32'hDEADBEEF); expQ.push_back(32'h0);
    #1;
    exp = expQ.pop_front(); checks++;
    if (reg1Out !== exp) begin errors++; $display("FAIL full_bypass: got %h expected %h", reg1Out, exp); end
    checks++;
    if (wrDropped !== 1'b0) begin errors++; $display("FAIL idle_no_drop: got %b expected 0", wrDropped); end
    @(negedge clk); regWrEn = 0;
    expQ.push_back(32'hDEADBEEF);
    #1;
    exp = expQ.pop_front(); checks++;
    if (reg2Out !== exp) begin errors++; $display("FAIL full_reg2_zero: got %h expected %h", reg2Out, exp); end
    exp = expQ.pop_front(); checks++;
    if (reg1Out !== exp) begin errors++; $display("FAIL full_stored: got %h expected %h", reg1Out, exp); end
  endtask

  task automatic test_masked_write();
    @(negedge clk);
    regWrEn = 1; regToWrite = 1; regWriteData = 32'h11223344; wrMask = 4'b0101; rSel1 = 1; rSel2 = 1;
    expQ.push_back(32'hDE22BE44); expQ.push_back(32'hDE22BE44);
    #1;
    exp = expQ.pop_front(); checks++;
    if (reg1Out !== exp) begin errors++; $display("FAIL mask_bypass1: got %h expected %h", reg1Out, exp); end
    exp = expQ.pop_front(); checks++;
    if (reg2Out !== exp) begin errors++; $display("FAIL mask_bypass2: got %h expected %h", reg2Out, exp); end
    @(negedge clk); regWrEn = 0;
    expQ.push_back(32'hDE22BE44);
    #1;
    exp = expQ.pop_front(); checks++;
    if (reg1Out !== exp) begin errors++; $display("FAIL mask_stored: got %h expected %h", reg1Out, exp); end
  endtask

  task automatic test_pending();
    @(negedge clk);
    pendSet = 1; pendSel = 5; rSel1 = 5; rSel2 = 0;
    @(negedge clk); pendSet = 0;
    #1; checks++;
    if ({pendVec[5], pend1, pend2} !== 3'b110) begin errors++; $display("FAIL pend_set: got %b%b%b expected 110", pendVec[5], pend1, pend2); end
    doWrite(5, 32'h01020304, 4'hF);
    #1; checks++;
    if (pendVec[5] !== 1'b0) begin errors++; $display("FAIL pend_clear_by_write: got %b expected 0", pendVec[5]); end
    @(negedge clk);
    pendSet = 1; pendSel = 5; regWrEn = 1; regToWrite = 5; regWriteData = 32'h0A0B0C0D; wrMask = 4'hF;
    @(negedge clk); pendSet = 0; regWrEn = 0;
    #1; checks++;
    if (pendVec !== 8'h20) begin errors++; $display("FAIL pend_set_wins: got %h expected 20", pendVec); end
  endtask

  task automatic test_clear_sweep();
    int busyCnt = 0;
    int doneAt  = 0;
    doWrite(3, 32'h1A2B3C4D, 4'hF);
    @(negedge clk); clrReq = 1;
    @(negedge clk); clrReq = 0;
    for (int i = 1; i <= 14; i++) begin
      if (i == 2) begin
        regWrEn = 1; regToWrite = 3; regWriteData = 32'hFFFFFFFF; wrMask = 4'hF; rSel1 = 3;
        clrReq = 1; pendSet = 1; pendSel = 6;
        expQ.push_back(32'h1A2B3C4D);
      end else begin
        idleInputs();
      end
      #1;
      if (clrBusy) busyCnt++;
      if (clrDone) doneAt = i;
      if (i == 2) begin
        checks++;
        if (wrDropped !== 1'b1) begin errors++; $display("FAIL sweep_drop_pulse: got %b expected 1", wrDropped); end
        exp = expQ.pop_front(); checks++;
        if (reg1Out !== exp) begin errors++; $display("FAIL sweep_no_bypass: got %h expected %h", reg1Out, exp); end
      end
      @(negedge clk);
    end
    checks++;
    if (busyCnt !== 9) begin errors++; $display("FAIL clr_busy_cycles: got %0d expected 9", busyCnt); end
    checks++;
    if (doneAt !== 9) begin errors++; $display("FAIL clr_done_cycle: got %0d expected 9", doneAt); end
    rSel1 = 1; rSel2 = 3;
    expQ.push_back(32'h0); expQ.push_back(32'h0);
    #1;
    exp = expQ.pop_front(); checks++;
    if (reg1Out !== exp) begin errors++; $display("FAIL clr_reg1: got %h expected %h", reg1Out, exp); end
    exp = expQ.pop_front(); checks++;
    if (reg2Out !== exp) begin errors++; $display("FAIL clr_reg3_after_drop: got %h expected %h", reg2Out, exp); end
    checks++;
    if (pendVec !== 8'h00) begin errors++; $display("FAIL clr_pend: got %h expected 00", pendVec); end
  endtask

  task automatic test_write_with_clear();
    int waited = 0;
    @(negedge clk);
    regWrEn = 1; regToWrite = 4; regWriteData = 32'h55667788; wrMask = 4'hF; clrReq = 1; rSel1 = 4;
    expQ.push_back(32'h55667788); expQ.push_back(32'h0);
    @(negedge clk); idleInputs();
    #1;
    exp = expQ.pop_front(); checks++;
    if (reg1Out !== exp) begin errors++; $display("FAIL wrclr_accepted: got %h expected %h", reg1Out, exp); end
    while (!clrDone && waited < 40) begin
      @(negedge clk); #1; waited++;
    end
    checks++;
    if (!clrDone) begin errors++; $display("FAIL wrclr_done_timeout: got no clrDone expected one within 40 cycles"); end
    @(negedge clk); #1;
    exp = expQ.pop_front(); checks++;
    if (reg1Out !== exp) begin errors++; $display("FAIL wrclr_final_zero: got %h expected %h", reg1Out, exp); end
  endtask

  task automatic test_reset_mid_sweep();
    doWrite(7, 32'hCAFEF00D, 4'hF);
    rSel1 = 7;
    @(negedge clk); clrReq = 1;
    @(negedge clk); clrReq = 0;
    repeat (3) @(negedge clk);
    expQ.push_back(32'hCAFEF00D); expQ.push_back(32'h0);
    #1;
    exp = expQ.pop_front(); checks++;
    if (reg1Out !== exp) begin errors++; $display("FAIL midsweep_before: got %h expected %h", reg1Out, exp); end
    reset = 0; regWrEn = 1; regToWrite = 7; regWriteData = 32'h12345678; wrMask = 4'h0;
    #1;
    exp = expQ.pop_front(); checks++;
    if (reg1Out !== exp) begin errors++; $display("FAIL midsweep_reg_zero: got %h expected %h", reg1Out, exp); end
    checks++;
    if ({clrBusy, clrDone, wrDropped} !== 3'b000) begin
      errors++; $display("FAIL midsweep_flags: got busy=%b done=%b drop=%b expected 000", clrBusy, clrDone, wrDropped);
    end
    @(negedge clk); regWrEn = 0;
    @(negedge clk); reset = 1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk); #1; checks++;
      if (clrBusy !== 1'b0) begin errors++; $display("FAIL midsweep_busy_after_release: got %b expected 0 (cycle %0d)", clrBusy, i); end
    end
  endtask

  initial begin
    test_reset();
    test_write_full();
    test_masked_write();
    test_pending();
    test_clear_sweep();
    test_write_with_clear();
    test_reset_mid_sweep();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/vector_reg_file_masked.md
VECTOR_REG_FILE_MASKED -- requirements
Module: vector_reg_file_masked

Interface
REQ-001 SHALL have parameter regSize, default 8: bits per vector element.
REQ-002 SHALL have parameter regQuantity, default 8: number of vector registers.
REQ-003 SHALL have parameter selBits, default 3: register select width, equal to clog2(regQuantity).
REQ-004 SHALL have parameter vecSize, default 4: elements (lanes) per vector.
REQ-005 SHALL have port clk, input, 1 bit: the single clock; all state updates on the rising edge.
REQ-006 SHALL have port reset, input, 1 bit: asynchronous, active-low reset.
REQ-007 SHALL have port regWrEn, input, 1 bit: write request.
REQ-008 SHALL have port regToWrite, input, selBits: write register select.
REQ-009 SHALL have port regWriteData, input, packed [vecSize-1:0][regSize-1:0]: write vector.
REQ-010 SHALL have port wrMask, input, vecSize bits: per-lane write enable; bit i gates lane i.
REQ-011 SHALL have ports rSel1 and rSel2, input, selBits each: read selects.
REQ-012 SHALL have ports reg1Out and reg2Out, output, packed [vecSize-1:0][regSize-1:0]: read data.
REQ-013 SHALL have port clrReq, input, 1 bit: request to zero all registers.
REQ-014 SHALL have port clrBusy, output, 1 bit: clear sweep in progress.
REQ-015 SHALL have port clrDone, output, 1 bit: one-cycle pulse when the sweep completes.
REQ-016 SHALL have port wrDropped, output, 1 bit: one-cycle pulse when a write is discarded.
REQ-017 SHALL have ports pendSet (input, 1 bit) and pendSel (input, selBits): mark a register as pending a write.
REQ-018 SHALL have port pendVec, output, regQuantity bits: pending flags.
REQ-019 SHALL have ports pend1 and pend2, output, 1 bit each: pending flags for rSel1 and rSel2.

Function
REQ-020 Write: on a rising edge with regWrEn=1 and the FSM in IDLE, each lane i of register regToWrite SHALL load regWriteData[i] only where wrMask[i]=1; the other lanes hold.
REQ-021 Reads SHALL be combinational, with one bypass: if regWrEn=1, FSM is IDLE and rSelN==regToWrite, masked lanes show regWriteData and unmasked lanes show the stored value.
REQ-022 Both read ports SHALL be independent; the same register on both ports is legal.
REQ-023 Clear FSM states SHALL be IDLE, SWEEP and DONE.
- IDLE->SWEEP on clrReq=1; the sweep counter loads 0.
- SWEEP: each cycle zeroes register[counter] and increments the counter; at counter=regQuantity-1 the FSM moves to DONE.
- DONE->IDLE after exactly one cycle.
REQ-024 clrBusy SHALL be 1 in SWEEP and DONE; clrDone SHALL be 1 only in DONE. Total clear latency is regQuantity+1 cycles from the accepting edge.
REQ-025 clrReq in SWEEP or DONE SHALL be ignored, with no restart.
REQ-026 A write presented while clrBusy=1 SHALL be discarded, and wrDropped SHALL pulse high for that cycle.
REQ-027 During SWEEP, reads SHALL return stored contents with no bypass.
REQ-028 pendSet=1 SHALL set pendVec[pendSel] at the edge.
REQ-029 An accepted write SHALL clear pendVec[regToWrite].
REQ-030 If pendSet and an accepted write target the same register in the same cycle, the set SHALL win.
REQ-031 Entering SWEEP SHALL clear all pendVec bits; pendSet during SWEEP/DONE SHALL be ignored.
REQ-032 pend1 and pend2 SHALL equal pendVec[rSel1] and pendVec[rSel2] combinationally.
REQ-033 clrReq and regWrEn in the same IDLE cycle: the write SHALL be accepted at that edge, then the sweep starts, so the final value is zero.

Reset
REQ-034 reset=0 SHALL immediately, without a clock, zero all registers and pendVec, force the FSM to IDLE with counter 0, and drive clrBusy, clrDone and wrDropped to 0.
REQ-035 reset asserted mid-sweep SHALL abort the sweep; after release the block SHALL be in IDLE with all registers zero.

Verification
REQ-036 After reset, write reg1=32'hDEADBEEF with mask 4'hF -> reg1Out=DE,AD,BE,EF on lanes 3..0; reg2Out (rSel2=0) is 0.
REQ-037 Write reg1 with 32'h11223344 and mask 4'b0101 -> reg1 reads DE,22,BE,44; the bypass shows the same value in the write cycle before the edge.
REQ-038 Write reg3=32'h1A2B3C4D, then assert clrReq for 1 cycle -> clrBusy is high for 9 cycles, clrDone pulses in the 9th, and regs 1 and 3 read 0.
REQ-039 Write attempted during the sweep -> wrDropped pulses and the register remains 0 after clrDone.
REQ-040 pendSet reg5, then write reg5 -> pendVec[5] goes 1 then 0; pendSet and write to reg5 in the same cycle -> pendVec[5]=1.
REQ-041 reset pulsed low at the 4th sweep cycle -> outputs are 0 immediately, and clrBusy stays 0 after release.
